// File: rtl/mips_mc_controller_if.sv
`default_nettype none
// ============================================================================
//  Module      : mips_mc_controller_if
//  Description : Control bundle between the multicycle MIPS controller and
//                its datapath. The controller side (master) receives the
//                instruction opcode, ALU zero flag and stall, and drives every
//                write enable and mux select.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mips_mc_controller_if;
  logic       stall;
  logic [5:0] opcode;
  logic       zero;
  logic       ir_we;
  logic       pc_we;
  logic [1:0] pc_src;
  logic       iord;
  logic       mem_we;
  logic       rfd_sel;
  logic       mem_to_rf_sel;
  logic       rfwe;
  logic       alu_a_sel;
  logic [1:0] alu_b_sel;
  logic [1:0] alu_op;
  logic [3:0] state;
  logic       illegal;

  // Controller side
  modport master (
    input  stall, opcode, zero,
    output ir_we, pc_we, pc_src, iord, mem_we, rfd_sel, mem_to_rf_sel,
           rfwe, alu_a_sel, alu_b_sel, alu_op, state, illegal
  );

  // Datapath side
  modport slave (
    output stall, opcode, zero,
    input  ir_we, pc_we, pc_src, iord, mem_we, rfd_sel, mem_to_rf_sel,
           rfwe, alu_a_sel, alu_b_sel, alu_op, state, illegal
  );
endinterface
`default_nettype wire

// File: rtl/mips_mc_controller.sv
`default_nettype none
// ============================================================================
//  Module      : mips_mc_controller
//  Description : Moore FSM controller for a multicycle, word-addressed MIPS
//                subset (lw, sw, R-type, beq, j, addi). Outputs decode from
//                the registered state only; pc_we additionally follows the
//                ALU zero flag in BRANCH. Stall and reset mask the writes.
//  Revision    : 1.0 - initial release
// ============================================================================
module mips_mc_controller #(
  parameter int ILLEGAL_HALT = 1
) (
  input  wire logic             clk,
  input  wire logic             rst,
  mips_mc_controller_if.master  bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC     = 4'd6,
    S_ALU_WB   = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_ADDI_EX  = 4'd10,
    S_ADDI_WB  = 4'd11,
    S_ILLEGAL  = 4'd15
  } state_t;

  localparam logic [5:0] c_OP_RTYPE = 6'h00;
  localparam logic [5:0] c_OP_J     = 6'h02;
  localparam logic [5:0] c_OP_BEQ   = 6'h04;
  localparam logic [5:0] c_OP_ADDI  = 6'h08;
  localparam logic [5:0] c_OP_LW    = 6'h23;
  localparam logic [5:0] c_OP_SW    = 6'h2B;

  state_t     r_state;
  state_t     w_next_state;

  logic       w_ir_we;
  logic       w_pc_we;
  logic [1:0] w_pc_src;
  logic       w_iord;
  logic       w_mem_we;
  logic       w_rfd_sel;
  logic       w_mem_to_rf_sel;
  logic       w_rfwe;
  logic       w_alu_a_sel;
  logic [1:0] w_alu_b_sel;
  logic [1:0] w_alu_op;
  logic       w_illegal;
  logic       w_wr_mask;

  // State register: async reset to FETCH, hold while stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_FETCH;
    end else if (!bus.stall) begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: opcode dispatch in DECODE and MEM_ADDR, fixed chains elsewhere
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_FETCH:    w_next_state = S_DECODE;
      S_DECODE: begin
        case (bus.opcode)
          c_OP_RTYPE:        w_next_state = S_EXEC;
          c_OP_LW, c_OP_SW:  w_next_state = S_MEM_ADDR;
          c_OP_BEQ:          w_next_state = S_BRANCH;
          c_OP_J:            w_next_state = S_JUMP;
          c_OP_ADDI:         w_next_state = S_ADDI_EX;
          default:           w_next_state = (ILLEGAL_HALT != 0) ? S_ILLEGAL : S_FETCH;
        endcase
      end
      S_MEM_ADDR: w_next_state = (bus.opcode == c_OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   w_next_state = S_MEM_WB;
      S_MEM_WB:   w_next_state = S_FETCH;
      S_MEM_WR:   w_next_state = S_FETCH;
      S_EXEC:     w_next_state = S_ALU_WB;
      S_ALU_WB:   w_next_state = S_FETCH;
      S_BRANCH:   w_next_state = S_FETCH;
      S_JUMP:     w_next_state = S_FETCH;
      S_ADDI_EX:  w_next_state = S_ADDI_WB;
      S_ADDI_WB:  w_next_state = S_FETCH;
      S_ILLEGAL:  w_next_state = S_ILLEGAL;
      // Unused encodings recover to a clean fetch
      default:    w_next_state = S_FETCH;
    endcase
  end

  // Output decode from the registered state; anything not named stays 0
  always_comb begin
    w_ir_we         = 1'b0;
    w_pc_we         = 1'b0;
    w_pc_src        = 2'b00;
    w_iord          = 1'b0;
    w_mem_we        = 1'b0;
    w_rfd_sel       = 1'b0;
    w_mem_to_rf_sel = 1'b0;
    w_rfwe          = 1'b0;
    w_alu_a_sel     = 1'b0;
    w_alu_b_sel     = 2'b00;
    w_alu_op        = 2'b00;
    w_illegal       = 1'b0;
    case (r_state)
      S_FETCH: begin
        // PC + 1 written back to PC while the instruction is latched
        w_ir_we     = 1'b1;
        w_pc_we     = 1'b1;
        w_alu_b_sel = 2'b01;
      end
      S_DECODE: begin
        // Speculative branch target PC+1+imm lands in ALUOut
        w_alu_b_sel = 2'b10;
      end
      S_MEM_ADDR: begin
        w_alu_a_sel = 1'b1;
        w_alu_b_sel = 2'b10;
      end
      S_MEM_RD: begin
        w_iord = 1'b1;
      end
      S_MEM_WB: begin
        w_rfwe          = 1'b1;
        w_mem_to_rf_sel = 1'b1;
      end
      S_MEM_WR: begin
        w_iord   = 1'b1;
        w_mem_we = 1'b1;
      end
      S_EXEC: begin
        w_alu_a_sel = 1'b1;
        w_alu_op    = 2'b10;
      end
      S_ALU_WB: begin
        w_rfwe    = 1'b1;
        w_rfd_sel = 1'b1;
      end
      S_BRANCH: begin
        // Compare A-B; take the ALUOut target only when equal
        w_alu_a_sel = 1'b1;
        w_alu_op    = 2'b01;
        w_pc_src    = 2'b01;
        w_pc_we     = bus.zero;
      end
      S_JUMP: begin
        w_pc_src = 2'b10;
        w_pc_we  = 1'b1;
      end
      S_ADDI_EX: begin
        w_alu_a_sel = 1'b1;
        w_alu_b_sel = 2'b10;
      end
      S_ADDI_WB: begin
        w_rfwe = 1'b1;
      end
      S_ILLEGAL: begin
        w_illegal = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Writes are suppressed during stall and while reset is held; selects are left alone
  assign w_wr_mask         = bus.stall | rst;

  assign bus.ir_we         = w_ir_we  & ~w_wr_mask;
  assign bus.pc_we         = w_pc_we  & ~w_wr_mask;
  assign bus.mem_we        = w_mem_we & ~w_wr_mask;
  assign bus.rfwe          = w_rfwe   & ~w_wr_mask;
  assign bus.pc_src        = w_pc_src;
  assign bus.iord          = w_iord;
  assign bus.rfd_sel       = w_rfd_sel;
  assign bus.mem_to_rf_sel = w_mem_to_rf_sel;
  assign bus.alu_a_sel     = w_alu_a_sel;
  assign bus.alu_b_sel     = w_alu_b_sel;
  assign bus.alu_op        = w_alu_op;
  assign bus.illegal       = w_illegal;
  assign bus.state         = r_state;

endmodule
`default_nettype wire
